tt_ctrl_sel: RTL and testbench

TT_CTRL_SEL -- requirements
Module: tt_ctrl_sel

---
 rtl/tt_pkg.sv | 20 ++
 rtl/tt_sync_edge.sv | 35 +++
 rtl/tt_ctrl_sel.sv | 158 +++++++++++++++
 tb/tb_tt_ctrl_sel.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tt_pkg                                                                 |
// | Shared state encoding and default sizes for the control selector.      |
// | Rev 1.0 - initial release                                              |
// +-----------------------------------------------------------------------+
package tt_pkg;

    localparam int unsigned TT_ADDR_W      = 10;
    localparam int unsigned TT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PAUSE  = 2'd3
    } sel_state_e;

endpackage
`default_nettype wire

// File: rtl/tt_sync_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tt_sync_edge                                                           |
// | Multi-stage synchronizer for an async pad with rising-edge detect.     |
// | Rev 1.0 - initial release                                              |
// +-----------------------------------------------------------------------+
module tt_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    // One-cycle pulse on the first synchronized high sample of each pad pulse.
    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/tt_ctrl_sel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tt_ctrl_sel                                                            |
// | Pad-driven user-module selector: count inc pulses, commit on ena.      |
// | Rev 1.0 - initial release                                              |
// +-----------------------------------------------------------------------+
module tt_ctrl_sel
    import tt_pkg::*;
#(
    parameter int unsigned ADDR_W      = TT_ADDR_W,
    parameter int unsigned SYNC_STAGES = TT_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pad_sel_rst_n,
    input  logic              pad_sel_inc,
    input  logic              pad_ena,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_addr_vld,
    output logic              sel_ena,
    output logic [ADDR_W-1:0] sel_cnt,
    output logic              sel_ovf,
    output logic              sel_err
);

    localparam logic [ADDR_W-1:0] c_CNT_MAX = {ADDR_W{1'b1}};

    logic w_rst_sync;
    logic w_inc_evt;
    logic w_ena_sync;
    logic w_unused_rst_rise;
    logic w_unused_ena_rise;
    logic w_unused_inc_sync;

    sel_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              vld_q,   vld_d;
    logic              ena_q,   ena_d;
    logic              ovf_q,   ovf_d;
    logic              err_q,   err_d;

    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rst (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (pad_sel_rst_n),
        .sync_o (w_rst_sync),
        .rise_o (w_unused_rst_rise)
    );

    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_inc (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (pad_sel_inc),
        .sync_o (w_unused_inc_sync),
        .rise_o (w_inc_evt)
    );

    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ena (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (pad_ena),
        .sync_o (w_ena_sync),
        .rise_o (w_unused_ena_rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        ena_d   = ena_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        if (!w_rst_sync) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            addr_d  = '0;
            vld_d   = 1'b0;
            ena_d   = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    if (w_inc_evt) begin
                        if (cnt_q == c_CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // Commit sees the post-increment count when both land together.
                    if (w_ena_sync) begin
                        addr_d  = cnt_d;
                        vld_d   = 1'b1;
                        ena_d   = 1'b1;
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_inc_evt) begin
                        err_d = 1'b1;
                    end
                    if (!w_ena_sync) begin
                        ena_d   = 1'b0;
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_inc_evt) begin
                        err_d = 1'b1;
                    end
                    if (w_ena_sync) begin
                        ena_d   = 1'b1;
                        state_d = ST_ACTIVE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            ena_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            ena_q   <= ena_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign sel_addr     = addr_q;
    assign sel_addr_vld = vld_q;
    assign sel_ena      = ena_q;
    assign sel_cnt      = cnt_q;
    assign sel_ovf      = ovf_q;
    assign sel_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_ctrl_sel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_tt_ctrl_sel                                                         |
// | Scoreboard bench for tt_ctrl_sel (ADDR_W=4, SYNC_STAGES=2).            |
// | Rev 1.0 - initial release                                              |
// +-----------------------------------------------------------------------+
module tb_tt_ctrl_sel;

    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              pad_sel_rst_n;
    logic              pad_sel_inc;
    logic              pad_ena;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_addr_vld;
    logic              sel_ena;
    logic [ADDR_W-1:0] sel_cnt;
    logic              sel_ovf;
    logic              sel_err;

    tt_ctrl_sel #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pad_sel_rst_n (pad_sel_rst_n),
        .pad_sel_inc   (pad_sel_inc),
        .pad_ena       (pad_ena),
        .sel_addr      (sel_addr),
        .sel_addr_vld  (sel_addr_vld),
        .sel_ena       (sel_ena),
        .sel_cnt       (sel_cnt),
        .sel_ovf       (sel_ovf),
        .sel_err       (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {addr, vld, ena, cnt, ovf, err}
    logic [11:0] obs;
    assign obs = {sel_addr, sel_addr_vld, sel_ena, sel_cnt, sel_ovf, sel_err};

    typedef struct {
        string       name;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t it;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [11:0] pk(input logic [3:0] a, input logic v, input logic e,
                                       input logic [3:0] c, input logic o, input logic r);
        return {a, v, e, c, o, r};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_inc(input int hi, input int lo);
        pad_sel_inc = 1'b1;
        cycles(hi);
        pad_sel_inc = 1'b0;
        cycles(lo);
    endtask

    task automatic do_clear();
        pad_ena       = 1'b0;
        pad_sel_inc   = 1'b0;
        pad_sel_rst_n = 1'b0;
        cycles(4);
        pad_sel_rst_n = 1'b1;
        cycles(5);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        pad_sel_rst_n = 1'b1;
        pad_sel_inc   = 1'b0;
        pad_ena       = 1'b1;
        sb.push_back('{"reset_hold", pk(0, 0, 0, 0, 0, 0)});
        cycles(4);
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pad_ena = 1'b0;
        rst_n   = 1'b1;
        cycles(5);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) pulse_inc(4, 4);
        sb.push_back('{"basic_count5", pk(0, 0, 0, 5, 0, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pad_ena = 1'b1;
        sb.push_back('{"latency_edge2", pk(0, 0, 0, 5, 0, 0)});
        sb.push_back('{"latency_edge3", pk(5, 1, 1, 5, 0, 0)});
        cycles(2);
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        cycles(1);
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
    endtask

    task automatic test_sel_rst();
        pad_sel_rst_n = 1'b0;
        sb.push_back('{"selrst_clear", pk(0, 0, 0, 0, 0, 0)});
        cycles(3);
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pad_sel_rst_n = 1'b1;
        pad_ena       = 1'b0;
        cycles(5);
    endtask

    task automatic test_hold_inc();
        pulse_inc(20, 4);
        sb.push_back('{"hold_inc_once", pk(0, 0, 0, 1, 0, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
    endtask

    task automatic test_ovf();
        do_clear();
        for (int i = 0; i < 15; i++) pulse_inc(2, 2);
        cycles(3);
        sb.push_back('{"ovf_at15", pk(0, 0, 0, 15, 0, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pulse_inc(2, 2);
        cycles(3);
        sb.push_back('{"ovf_pulse16", pk(0, 0, 0, 15, 1, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pulse_inc(2, 2);
        cycles(3);
        sb.push_back('{"ovf_pulse17", pk(0, 0, 0, 15, 1, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pad_ena = 1'b1;
        cycles(4);
        sb.push_back('{"ovf_commit", pk(15, 1, 1, 15, 1, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
    endtask

    task automatic test_pause();
        do_clear();
        for (int i = 0; i < 3; i++) pulse_inc(4, 4);
        pad_ena = 1'b1;
        cycles(4);
        sb.push_back('{"pause_active3", pk(3, 1, 1, 3, 0, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pad_ena = 1'b0;
        cycles(4);
        sb.push_back('{"pause_drop_ena", pk(3, 1, 0, 3, 0, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pulse_inc(4, 4);
        sb.push_back('{"pause_inc_err", pk(3, 1, 0, 3, 0, 1)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pad_ena = 1'b1;
        cycles(4);
        sb.push_back('{"pause_resume", pk(3, 1, 1, 3, 0, 1)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        pulse_inc(4, 4);
        sb.push_back('{"active_inc_err", pk(3, 1, 1, 3, 0, 1)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
    endtask

    task automatic test_align();
        do_clear();
        for (int i = 0; i < 7; i++) pulse_inc(3, 3);
        pad_sel_inc = 1'b1;
        pad_ena     = 1'b1;
        cycles(4);
        pad_sel_inc = 1'b0;
        cycles(2);
        sb.push_back('{"align_inc_ena", pk(8, 1, 1, 8, 0, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
    endtask

    task automatic test_async_reset();
        do_clear();
        pulse_inc(4, 4);
        pulse_inc(4, 4);
        sb.push_back('{"async_precount", pk(0, 0, 0, 2, 0, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back('{"async_clear", pk(0, 0, 0, 0, 0, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
        cycles(2);
        rst_n = 1'b1;
        cycles(5);
        pulse_inc(4, 4);
        sb.push_back('{"async_fresh", pk(0, 0, 0, 1, 0, 0)});
        it = sb.pop_front(); n_cmp++;
        if (obs !== it.exp) begin n_err++; $display("FAIL %s: got %h required %h", it.name, obs, it.exp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sel_rst();
        test_hold_inc();
        test_ovf();
        test_pause();
        test_align();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
